// File: rtl/cmp_pkg.sv
// Shared definitions for the threshold monitor: default widths, run-counter
// width, the three-flag compare result and the saturating counter helper.
package cmp_pkg;

   localparam int W_DEF       = 4;
   localparam int RUN_LEN_DEF = 4;
   localparam int CNT_W       = 4;

   typedef struct packed {
      logic equal;
      logic greater;
      logic lower;
   } flags_t;

   // Increment that sticks at lim once reached.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
      if (v >= lim) begin
         return lim;
      end
      return v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cmp_core.sv
// Pure combinational unsigned compare of a against b, producing exactly one
// of equal / greater / lower.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output flags_t       flags
);

   always_comb begin
      flags.equal   = (a == b);
      flags.greater = (a > b);
      flags.lower   = (a < b);
   end

endmodule

// File: rtl/cmp_threshold_monitor.sv
// Streams samples against a loadable threshold, registers the compare flags
// behind a valid/ready stage and raises a sticky alarm on a run of greater
// samples. Defining CMP_MINMAX_EN adds min_val/max_val extreme tracking.
module cmp_threshold_monitor
   import cmp_pkg::*;
#(
   parameter int RUN_LEN = RUN_LEN_DEF,
   parameter int W       = W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [W-1:0]     thr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             equal,
   output logic             greater,
   output logic             lower,
   output logic [CNT_W-1:0] run_cnt,
   output logic             alarm,
   input  logic             alarm_clr
`ifdef CMP_MINMAX_EN
   ,
   output logic [W-1:0]     min_val,
   output logic [W-1:0]     max_val
`endif
);

   localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_LEN);

   logic [W-1:0]     thr_reg;
   flags_t           cmp_flags;
   flags_t           flags_reg;
   logic             out_valid_reg;
   logic [CNT_W-1:0] run_cnt_reg;
   logic [CNT_W-1:0] run_cnt_next;
   logic             alarm_reg;
   logic             alarm_next;
   logic             alarm_set;
   logic             accept;

   assign in_ready = !out_valid_reg || out_ready;
   assign accept   = in_valid && in_ready;

   // Compare against the threshold currently held, so a coincident load
   // only affects later samples.
   cmp_core #(
      .W (W)
   ) u_core (
      .a     (a),
      .b     (thr_reg),
      .flags (cmp_flags)
   );

   always_comb begin
      run_cnt_next = run_cnt_reg;
      alarm_set    = 1'b0;
      if (load) begin
         run_cnt_next = '0;
      end else if (accept) begin
         if (cmp_flags.greater) begin
            run_cnt_next = sat_inc(run_cnt_reg, RUN_LIM);
            alarm_set    = (run_cnt_reg != RUN_LIM) && (run_cnt_next == RUN_LIM);
         end else begin
            run_cnt_next = '0;
         end
      end
   end

   // A new alarm outranks a clear arriving in the same cycle.
   always_comb begin
      alarm_next = alarm_reg;
      if (alarm_set) begin
         alarm_next = 1'b1;
      end else if (alarm_clr || load) begin
         alarm_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         thr_reg       <= '0;
         out_valid_reg <= 1'b0;
         flags_reg     <= '0;
         run_cnt_reg   <= '0;
         alarm_reg     <= 1'b0;
      end else begin
         if (load) begin
            thr_reg <= thr;
         end
         if (accept) begin
            out_valid_reg <= 1'b1;
            flags_reg     <= cmp_flags;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
         run_cnt_reg <= run_cnt_next;
         alarm_reg   <= alarm_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign equal     = flags_reg.equal;
   assign greater   = flags_reg.greater;
   assign lower     = flags_reg.lower;
   assign run_cnt   = run_cnt_reg;
   assign alarm     = alarm_reg;

`ifdef CMP_MINMAX_EN
   logic [W-1:0] min_reg;
   logic [W-1:0] max_reg;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         min_reg <= '1;
         max_reg <= '0;
      end else if (accept) begin
         if (a < min_reg) begin
            min_reg <= a;
         end
         if (a > max_reg) begin
            max_reg <= a;
         end
      end
   end

   assign min_val = min_reg;
   assign max_val = max_reg;
`endif

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Directed bench for cmp_threshold_monitor: a transaction-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_cmp_threshold_monitor;

   localparam int W       = 4;
   localparam int RUN_LEN = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] thr = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         equal, greater, lower;
   logic [3:0]   run_cnt;
   logic         alarm;
   logic         alarm_clr = 1'b0;
`ifdef CMP_MINMAX_EN
   logic [W-1:0] min_val, max_val;
`endif

   int checks = 0;
   int errors = 0;
   bit model_live = 1'b0;

   cmp_threshold_monitor #(.RUN_LEN(RUN_LEN), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .thr       (thr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .equal     (equal),
      .greater   (greater),
      .lower     (lower),
      .run_cnt   (run_cnt),
      .alarm     (alarm),
      .alarm_clr (alarm_clr)
`ifdef CMP_MINMAX_EN
      ,
      .min_val   (min_val),
      .max_val   (max_val)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the last accepted result, the threshold, the length of
   // the current run of greater samples and the alarm, as plain integers.
   int m_thr, m_last, m_run, m_min, m_max;
   bit m_valid, m_alarm;

   always @(posedge clk) begin
      bit acc;
      int old_run;
      if (rst) begin
         m_thr = 0; m_valid = 0; m_last = -1; m_run = 0; m_alarm = 0;
         m_min = 15; m_max = 0;
         model_live = 1'b1;
      end else begin
         acc = in_valid && (!m_valid || out_ready);
         old_run = m_run;
         if (acc) begin
            m_valid = 1;
            m_last  = int'(a);
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (load) begin
            m_run = 0;
            m_alarm = 0;
            m_min = 15; m_max = 0;
         end else begin
            if (acc) begin
               m_run = (int'(a) > m_thr) ? ((m_run < RUN_LEN) ? m_run + 1 : RUN_LEN) : 0;
               if (int'(a) < m_min) m_min = int'(a);
               if (int'(a) > m_max) m_max = int'(a);
            end
            if (old_run < RUN_LEN && m_run == RUN_LEN) m_alarm = 1;
            else if (alarm_clr) m_alarm = 0;
         end
         if (acc) m_last = m_last - m_thr;  // keep signed difference to the threshold used
         if (load) m_thr = int'(thr);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare of every output against the model.
   always @(posedge clk) begin
      #1;
      if (model_live) begin
         check("in_ready", int'(in_ready), int'(!m_valid || out_ready));
         check("out_valid", int'(out_valid), int'(m_valid));
         if (m_valid) begin
            check("greater", int'(greater), int'(m_last > 0));
            check("equal", int'(equal), int'(m_last == 0));
            check("lower", int'(lower), int'(m_last < 0));
         end
         check("run_cnt", int'(run_cnt), m_run);
         check("alarm", int'(alarm), int'(m_alarm));
`ifdef CMP_MINMAX_EN
         check("min_val", int'(min_val), m_min);
         check("max_val", int'(max_val), m_max);
`endif
      end
   end

   task automatic drive(input bit v, input int val, input bit rdy,
                        input bit ld, input int t, input bit clr);
      @(negedge clk);
      in_valid  = v;
      a         = W'(val);
      out_ready = rdy;
      load      = ld;
      thr       = W'(t);
      alarm_clr = clr;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic step(input bit v, input int val, input bit rdy,
                       input bit ld, input int t, input bit clr);
      drive(v, val, rdy, ld, t, clr);
      settle();
      $display("t=%0t v=%0b a=%0d rdy=%0b ld=%0b thr=%0d clr=%0b -> ov=%0b e/g/l=%0b%0b%0b cnt=%0d alarm=%0b",
               $time, v, val, rdy, ld, t, clr, out_valid, equal, greater, lower, run_cnt, alarm);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) settle();
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_run_cnt", int'(run_cnt), 0);
      check("reset_alarm", int'(alarm), 0);
      check("reset_flags", int'({equal, greater, lower}), 0);
      drive(0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      #1;
      check("first_in_ready", int'(in_ready), 1);
      settle();

      // Basic compares against thr=5
      step(0, 0, 1, 1, 5, 0);
      step(1, 3, 1, 0, 0, 0);
      check("basic_lower", int'({out_valid, lower}), 3);
      step(1, 5, 1, 0, 0, 0);
      check("basic_equal", int'({out_valid, equal}), 3);
      step(1, 9, 1, 0, 0, 0);
      check("basic_greater", int'({out_valid, greater}), 3);

      // Backpressure: sample 7 then hold for three cycles
      step(0, 0, 1, 1, 5, 0);
      step(1, 7, 0, 0, 0, 0);
      check("bp_greater", int'(greater), 1);
      check("bp_cnt", int'(run_cnt), 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 4, 0, 0, 0, 0);
         check("bp_hold_greater", int'({out_valid, greater}), 3);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_hold_cnt", int'(run_cnt), 1);
      end
      drive(1, 4, 1, 0, 0, 0);
      #1;
      check("bp_release_ready", int'(in_ready), 1);
      settle();
      check("bp_next_lower", int'({out_valid, lower}), 3);
      check("bp_next_cnt", int'(run_cnt), 0);

      // Alarm after four greater samples, saturation, clear
      step(0, 0, 1, 1, 2, 0);
      step(1, 8, 1, 0, 0, 0);
      step(1, 9, 1, 0, 0, 0);
      step(1, 10, 1, 0, 0, 0);
      check("alarm_before", int'(alarm), 0);
      check("cnt_three", int'(run_cnt), 3);
      step(1, 11, 1, 0, 0, 0);
      check("alarm_rise", int'({out_valid, alarm}), 3);
      check("cnt_four", int'(run_cnt), 4);
      step(1, 12, 1, 0, 0, 0);
      check("cnt_saturate", int'(run_cnt), 4);
      step(1, 1, 1, 0, 0, 0);
      check("cnt_cleared", int'(run_cnt), 0);
      check("alarm_sticky", int'(alarm), 1);
      step(0, 0, 1, 0, 0, 1);
      check("alarm_clr", int'(alarm), 0);

      // Set and clear in the same cycle: set wins
      step(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 1);
      check("alarm_set_wins", int'(alarm), 1);
      step(0, 0, 1, 1, 0, 0);
      check("load_clears_alarm", int'(alarm), 0);

      // Load coinciding with a sample uses the old threshold
      step(0, 0, 1, 1, 5, 0);
      step(1, 3, 1, 1, 1, 0);
      check("collide_lower", int'({out_valid, lower}), 3);
      check("collide_cnt", int'(run_cnt), 0);
      step(1, 3, 1, 0, 0, 0);
      check("collide_greater", int'({out_valid, greater}), 3);

      // Mixed stream with irregular output backpressure
      for (int i = 0; i < 16; i++) begin
         step((i % 5) != 4, (i * 7) % 16, (i % 3) != 1, 0, 0, 0);
      end

`ifdef CMP_MINMAX_EN
      step(0, 0, 1, 1, 5, 0);
      step(1, 6, 1, 0, 0, 0);
      step(1, 2, 1, 0, 0, 0);
      step(1, 12, 1, 0, 0, 0);
      check("minmax_min", int'(min_val), 2);
      check("minmax_max", int'(max_val), 12);
      step(0, 0, 1, 1, 5, 0);
      check("minmax_load_min", int'(min_val), 15);
      check("minmax_load_max", int'(max_val), 0);
`endif

      // Reset in the middle of a stalled transfer
      step(0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 9, 1, 0, 0, 0);
      step(1, 9, 0, 0, 0, 0);
      check("pre_rst_valid", int'(out_valid), 1);
      check("pre_rst_alarm", int'(alarm), 1);
      drive(1, 9, 0, 1, 3, 1);
      rst = 1'b1;
      settle();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_cnt", int'(run_cnt), 0);
      check("rst_alarm", int'(alarm), 0);
      check("rst_in_ready", int'(in_ready), 1);
      drive(0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      step(1, 1, 1, 0, 0, 0);
      check("post_rst_thr_zero", int'({out_valid, greater}), 3);
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
